// File: rtl/hilo_wb_unit_pkg.sv
// Shared constants for the HI/LO write-back slice.
// These mirror the legacy defines.v names (RstEnable, ZeroWord, WriteEnable/WriteDisable, RegBus, HiloCntBus).
package hilo_wb_unit_pkg;

  localparam logic     RST_ENABLE     = 1'b1;
  localparam logic     WRITE_ENABLE   = 1'b1;
  localparam logic     WRITE_DISABLE  = 1'b0;
  localparam int       REG_BUS_W      = 32;
  localparam int       HILO_CNT_BUS_W = 32;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/hilo_fwd_mux.sv
// HI/LO operand forwarding for the execute stage.
// The youngest writer wins: mem first, then wb, then the architectural value.
module hilo_fwd_mux #(
  parameter int DATA_W = 32
) (
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic [DATA_W-1:0] arch_hi,
  input  logic [DATA_W-1:0] arch_lo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  // HI and LO always select from the same source.
  always_comb begin
    hi_o = arch_hi;
    lo_o = arch_lo;
    if (mem_whilo) begin
      hi_o = mem_hi;
      lo_o = mem_lo;
    end else if (wb_whilo) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end
  end

endmodule

// File: rtl/hilo_wb_unit.sv
// HI/LO write-back stage: WB pipeline regs, architectural commit and execute-stage forwarding.
// Define HILO_PERF_EN to add the hilo_wr_cnt commit counter.
module hilo_wb_unit
  import hilo_wb_unit_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W
`ifdef HILO_PERF_EN
  , parameter int CNT_W = HILO_CNT_BUS_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] arch_hi,
  output logic [DATA_W-1:0] arch_lo
`ifdef HILO_PERF_EN
  , output logic [CNT_W-1:0] hilo_wr_cnt
`endif
);

  logic [DATA_W-1:0] wb_hi_q, wb_hi_d, wb_lo_q, wb_lo_d;
  logic              wb_whilo_q, wb_whilo_d;
  logic [DATA_W-1:0] arch_hi_q, arch_hi_d, arch_lo_q, arch_lo_d;
  logic              commit;

  // A flush squashes what enters WB, not what is already there, so it never blocks commit.
  assign commit = (wb_whilo_q == WRITE_ENABLE) && !stall;

  always_comb begin
    wb_hi_d    = wb_hi_q;
    wb_lo_d    = wb_lo_q;
    wb_whilo_d = wb_whilo_q;
    if (rst == RST_ENABLE || flush) begin
      wb_hi_d    = '0;
      wb_lo_d    = '0;
      wb_whilo_d = WRITE_DISABLE;
    end else if (!stall) begin
      wb_hi_d    = mem_hi;
      wb_lo_d    = mem_lo;
      wb_whilo_d = mem_whilo;
    end
  end

  always_comb begin
    arch_hi_d = arch_hi_q;
    arch_lo_d = arch_lo_q;
    if (rst == RST_ENABLE) begin
      arch_hi_d = '0;
      arch_lo_d = '0;
    end else if (commit) begin
      arch_hi_d = wb_hi_q;
      arch_lo_d = wb_lo_q;
    end
  end

  always_ff @(posedge clk) begin
    wb_hi_q    <= wb_hi_d;
    wb_lo_q    <= wb_lo_d;
    wb_whilo_q <= wb_whilo_d;
    arch_hi_q  <= arch_hi_d;
    arch_lo_q  <= arch_lo_d;
  end

`ifdef HILO_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rst == RST_ENABLE) cnt_d = '0;
    else if (commit)       cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) cnt_q <= cnt_d;

  assign hilo_wr_cnt = cnt_q;
`endif

  assign wb_hi    = wb_hi_q;
  assign wb_lo    = wb_lo_q;
  assign wb_whilo = wb_whilo_q;
  assign arch_hi  = arch_hi_q;
  assign arch_lo  = arch_lo_q;

  hilo_fwd_mux #(.DATA_W(DATA_W)) u_fwd (
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .wb_whilo  (wb_whilo_q),
    .wb_hi     (wb_hi_q),
    .wb_lo     (wb_lo_q),
    .arch_hi   (arch_hi_q),
    .arch_lo   (arch_lo_q),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

endmodule
